spi_flash_read_sequencer: RTL and testbench

- Sequences the team's byte-wide SPI master engine (start/busy/data_in/data_out handshake) to perform complete SPI-flash READ transactions.
- Each transaction is the opcode, then a 24-bit address MSB-first, then N data bytes.
- Owns flash chip-select across the whole multi-byte transfer and gates SCK to the flash outside byte transfers.
- Delivers read bytes on a valid/ready stream. Sits between boot/asset loaders and the byte engine.

---
 rtl/spi_flash_read_sequencer_pkg.sv | 35 +++
 rtl/spi_flash_read_sequencer_issuer.sv | 96 +++++++++
 rtl/spi_flash_read_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_spi_flash_read_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_read_sequencer_pkg.sv
// Shared definitions for the SPI-flash sequencers.
// Contents: main read-FSM state encoding, byte-issue handshake sub-state
// encoding, SPI-flash opcode constants, and a helper that identifies the
// FSM states which move one byte through the byte engine.
package spi_flash_read_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR2,
    ST_ADDR1,
    ST_ADDR0,
    ST_DATA,
    ST_HOLD,
    ST_FINISH
  } seq_state_e;

  typedef enum logic [1:0] {
    BI_IDLE,
    BI_ISSUE,
    BI_WAIT_HI,
    BI_WAIT_LO
  } issue_state_e;

  localparam logic [7:0] FLASH_OP_READ      = 8'h03;
  localparam logic [7:0] FLASH_OP_FAST_READ = 8'h0B;
  localparam logic [7:0] FLASH_OP_RDSR      = 8'h05;

  // States that hand one byte to the engine through the byte issuer.
  function automatic logic is_byte_state(input seq_state_e s);
    return (s == ST_CMD) || (s == ST_ADDR2) || (s == ST_ADDR1) ||
           (s == ST_ADDR0) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/spi_flash_read_sequencer_issuer.sv
// spi_byte_issuer: runs one start/busy handshake with the byte-wide SPI
// master engine and reports the received byte or a start timeout.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   go_i, tx_i        request to send tx_i (sampled only while idle)
//   byte_busy_i       engine busy
//   byte_rx_i         engine received byte (valid when busy falls)
//   byte_start_o      engine start, held until busy rises
//   byte_tx_o         engine transmit byte
//   rx_valid_o, rx_o  one-cycle pulse with the received byte
//   timeout_o         one-cycle pulse: busy never rose within START_TIMEOUT
module spi_byte_issuer
  import spi_flash_read_sequencer_pkg::*;
#(
  parameter int START_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic [7:0] tx_i,
  input  logic       byte_busy_i,
  input  logic [7:0] byte_rx_i,
  output logic       byte_start_o,
  output logic [7:0] byte_tx_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_o,
  output logic       timeout_o
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  issue_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;
  logic [7:0]       tx_q;
  logic             rx_valid_q;
  logic [7:0]       rx_q;
  logic             timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BI_IDLE;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      tx_q       <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_q       <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        BI_IDLE: begin
          if (go_i) begin
            tx_q    <= tx_i;
            state_q <= BI_ISSUE;
          end
        end
        BI_ISSUE: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= BI_WAIT_HI;
        end
        BI_WAIT_HI: begin
          // Start must drop on the same edge busy is seen, otherwise the
          // engine would take a second byte.
          if (byte_busy_i) begin
            start_q <= 1'b0;
            state_q <= BI_WAIT_LO;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            start_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= BI_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BI_WAIT_LO: begin
          if (!byte_busy_i) begin
            rx_q       <= byte_rx_i;
            rx_valid_q <= 1'b1;
            state_q    <= BI_IDLE;
          end
        end
        default: state_q <= BI_IDLE;
      endcase
    end
  end

  assign byte_start_o = start_q;
  assign byte_tx_o    = tx_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_o         = rx_q;
  assign timeout_o    = timeout_q;

endmodule

// File: rtl/spi_flash_read_sequencer.sv
// spi_flash_read_sequencer: performs complete SPI-flash READ transactions
// (opcode, 24-bit address MSB first, N data bytes) through the byte engine.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o         request handshake (ready only in IDLE)
//   req_addr_i, req_len_i           start address, byte count (0 = no-op)
//   rd_data_o/rd_valid_o/rd_ready_i read-byte stream, rd_last_o on final byte
//   done_o                          one-cycle pulse at transaction end
//   error_o                         sticky start-timeout flag
//   busy_o                          high from acceptance until done
//   byte_start_o/byte_tx_o          to byte engine
//   byte_busy_i/byte_rx_i/byte_sck_i from byte engine
//   flash_cs_n_o, flash_sck_o       flash chip select and gated clock
module spi_flash_read_sequencer
  import spi_flash_read_sequencer_pkg::*;
#(
  parameter logic [7:0] READ_CMD      = FLASH_OP_READ,
  parameter int         LEN_W         = 16,
  parameter int         START_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [23:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             rd_last_o,
  output logic             done_o,
  output logic             error_o,
  output logic             busy_o,
  output logic             byte_start_o,
  output logic [7:0]       byte_tx_o,
  input  logic             byte_busy_i,
  input  logic [7:0]       byte_rx_i,
  input  logic             byte_sck_i,
  output logic             flash_cs_n_o,
  output logic             flash_sck_o
);

  seq_state_e       state_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] remain_q;
  logic             pending_q;   // a byte is in flight in the issuer
  logic             req_ready_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;
  logic             rd_last_q;
  logic             done_q;
  logic             error_q;
  logic             busy_q;
  logic             cs_n_q;

  logic             go;
  logic [7:0]       tx_d;
  logic             rx_valid;
  logic [7:0]       rx;
  logic             timeout;

  // Each byte state fires the issuer once on entry, then waits for its result.
  assign go = is_byte_state(state_q) && !pending_q;

  always_comb begin
    tx_d = 8'h00;
    case (state_q)
      ST_CMD:   tx_d = READ_CMD;
      ST_ADDR2: tx_d = addr_q[23:16];
      ST_ADDR1: tx_d = addr_q[15:8];
      ST_ADDR0: tx_d = addr_q[7:0];
      default:  tx_d = 8'h00;
    endcase
  end

  spi_byte_issuer #(
    .START_TIMEOUT(START_TIMEOUT)
  ) u_issuer (
    .clk         (clk),
    .reset       (reset),
    .go_i        (go),
    .tx_i        (tx_d),
    .byte_busy_i (byte_busy_i),
    .byte_rx_i   (byte_rx_i),
    .byte_start_o(byte_start_o),
    .byte_tx_o   (byte_tx_o),
    .rx_valid_o  (rx_valid),
    .rx_o        (rx),
    .timeout_o   (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      pending_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (go) pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            addr_q      <= req_addr_i;
            remain_q    <= req_len_i;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            // Zero-length requests never touch the flash.
            if (req_len_i == '0) begin
              state_q <= ST_FINISH;
            end else begin
              cs_n_q  <= 1'b0;
              state_q <= ST_CMD;
            end
          end
        end
        ST_CMD, ST_ADDR2, ST_ADDR1, ST_ADDR0, ST_DATA: begin
          if (timeout) begin
            error_q   <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= ST_FINISH;
          end else if (rx_valid) begin
            pending_q <= 1'b0;
            case (state_q)
              ST_CMD:   state_q <= ST_ADDR2;
              ST_ADDR2: state_q <= ST_ADDR1;
              ST_ADDR1: state_q <= ST_ADDR0;
              ST_ADDR0: state_q <= ST_DATA;
              default: begin
                rd_data_q  <= rx;
                rd_valid_q <= 1'b1;
                rd_last_q  <= (remain_q == LEN_W'(1));
                state_q    <= ST_HOLD;
              end
            endcase
          end
        end
        ST_HOLD: begin
          // No new byte is issued until the consumer takes this one, so
          // backpressure parks the bus with CS low and SCK gated.
          if (rd_ready_i) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (remain_q != '0) remain_q <= remain_q - LEN_W'(1);
            if (remain_q <= LEN_W'(1)) state_q <= ST_FINISH;
            else                       state_q <= ST_DATA;
          end
        end
        ST_FINISH: begin
          cs_n_q      <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_last_o    = rd_last_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign busy_o       = busy_q;
  assign flash_cs_n_o = cs_n_q;
  // Mode-0 idle-low clock: only pass the engine clock while a byte shifts.
  assign flash_sck_o  = byte_busy_i ? byte_sck_i : 1'b0;

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
module tb_spi_flash_read_sequencer;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] len;
    logic [31:0] data;     // flash bytes at offsets 0..3, first in [31:24]
    logic        dead;     // engine never raises busy
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        done;
  logic        error;
  logic        busy;
  logic        byte_start;
  logic [7:0]  byte_tx;
  logic        byte_busy;
  logic [7:0]  byte_rx;
  logic        byte_sck;
  logic        flash_cs_n;
  logic        flash_sck;

  int n_chk = 0;
  int n_pass = 0;

  // engine + flash model state
  logic       eng_busy = 1'b0;
  logic       eng_sck = 1'b0;
  logic [7:0] eng_tx = 8'h00;
  logic [7:0] eng_rx = 8'h00;
  int         eng_cnt = 0;
  int         fl_idx = 0;
  int         bad_cs = 0;
  bit         eng_dead = 1'b0;
  logic [7:0] flash_mem [8];
  logic [7:0] mosi_q [$];
  logic [8:0] exp_q [$];
  vec_t       vecs [6];

  spi_flash_read_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_last_o   (rd_last),
    .done_o      (done),
    .error_o     (error),
    .busy_o      (busy),
    .byte_start_o(byte_start),
    .byte_tx_o   (byte_tx),
    .byte_busy_i (byte_busy),
    .byte_rx_i   (byte_rx),
    .byte_sck_i  (byte_sck),
    .flash_cs_n_o(flash_cs_n),
    .flash_sck_o (flash_sck)
  );

  assign byte_busy = eng_busy;
  assign byte_rx   = eng_rx;
  assign byte_sck  = eng_sck;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte engine: 16-cycle transfer, sck toggling while busy. The flash
  // returns 8'hFF during opcode/address and flash_mem[] for data bytes.
  always @(posedge clk) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_sck  <= 1'b0;
      eng_cnt  <= 0;
      fl_idx   <= 0;
    end else if (!eng_busy) begin
      eng_sck <= 1'b0;
      if (flash_cs_n) fl_idx <= 0;
      if (byte_start && !eng_dead) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 0;
        eng_tx   <= byte_tx;
      end
    end else begin
      eng_sck <= ~eng_sck;
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 15) begin
        eng_busy <= 1'b0;
        eng_sck  <= 1'b0;
        mosi_q.push_back(eng_tx);
        if (flash_cs_n) bad_cs <= bad_cs + 1;
        eng_rx <= (fl_idx >= 4) ? flash_mem[fl_idx-4] : 8'hFF;
        fl_idx <= fl_idx + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compare a byte the consumer is about to accept against the scoreboard.
  task automatic consume(output bit hs);
    logic [8:0] e;
    hs = 1'b0;
    if (rd_valid && rd_ready) begin
      hs = 1'b1;
      check("rd_expected_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e[8:1]));
        check("rd_last", 32'(rd_last), 32'(e[0]));
      end
    end
  endtask

  task automatic run_txn(input vec_t v, input int stall_after, input int stall_len);
    int cyc, hs_cnt, stall_left, cs_low, start_hi, rv, n_exp;
    bit got, hs, chg, bs_seen, sck_seen, cs_seen;
    logic [7:0] held, em;
    mosi_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) flash_mem[i] = v.data[31-8*i -: 8];
    eng_dead = v.dead;
    if (!v.dead)
      for (int i = 0; i < int'(v.len); i++)
        exp_q.push_back({v.data[31-8*i -: 8], 1'(i == int'(v.len) - 1)});
    hs_cnt = 0; stall_left = stall_len; cs_low = 0; start_hi = 0; rv = 0;
    got = 0; chg = 0; bs_seen = 0; sck_seen = 0; cs_seen = 0; held = 8'h00;

    @(negedge clk);
    req_addr = v.addr; req_len = v.len; req_valid = 1'b1; rd_ready = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready_before_accept", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    cyc = 0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("error_cleared_on_accept", 32'(error), 0);
        check("busy_after_accept", 32'(busy), 1);
        check("req_ready_while_busy", 32'(req_ready), 0);
      end
      if (!flash_cs_n) cs_low++;
      if (byte_start) start_hi++;
      if (rd_valid) rv++;
      if (stall_len > 0 && hs_cnt == stall_after && rd_valid && stall_left > 0) begin
        if (stall_left == stall_len) held = rd_data;
        rd_ready = 1'b0;
        stall_left--;
        if (rd_data !== held) chg = 1;
        if (byte_start) bs_seen = 1;
        if (flash_sck) sck_seen = 1;
        if (flash_cs_n) cs_seen = 1;
      end else begin
        rd_ready = 1'b1;
      end
      consume(hs);
      if (hs) hs_cnt++;
      if (done) got = 1;
    end
    check("done_seen", 32'(got), 1);

    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("cs_high_after", 32'(flash_cs_n), 1);
    check("byte_start_low_after", 32'(byte_start), 0);
    check("busy_low_after", 32'(busy), 0);
    check("error_after", 32'(error), 32'(v.exp_err));
    check("bytes_outside_cs", bad_cs, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    n_exp = (v.dead || v.len == 0) ? 0 : 4 + int'(v.len);
    check("mosi_count", mosi_q.size(), n_exp);
    if (mosi_q.size() == n_exp) begin
      for (int i = 0; i < n_exp; i++) begin
        case (i)
          0: em = 8'h03;
          1: em = v.addr[23:16];
          2: em = v.addr[15:8];
          3: em = v.addr[7:0];
          default: em = 8'h00;
        endcase
        check("mosi_byte", 32'(mosi_q[i]), 32'(em));
      end
    end
    if (v.len == 0) begin
      check("len0_done_latency", cyc, 2);
      check("len0_cs_never_low", cs_low, 0);
      check("len0_no_byte_start", start_hi, 0);
    end
    if (v.dead) begin
      check("timeout_start_cycles", 32'(start_hi >= 64 && start_hi <= 65), 1);
      check("timeout_no_rd_valid", rv, 0);
    end
    if (stall_len > 0) begin
      check("stall_completed", stall_left, 0);
      check("stall_data_stable", 32'(chg), 0);
      check("stall_no_byte_start", 32'(bs_seen), 0);
      check("stall_sck_gated", 32'(sck_seen), 0);
      check("stall_cs_low", 32'(cs_seen), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, acc, dn, gap, dn_at_acc2, busy_ready;
    bit  hs, got;
    vec_t v;

    vecs[0] = '{addr: 24'h0012AB, len: 16'd3, data: 32'hA55AC300, dead: 1'b0, exp_err: 1'b0};
    vecs[1] = '{addr: 24'h000000, len: 16'd0, data: 32'h00000000, dead: 1'b0, exp_err: 1'b0};
    vecs[2] = '{addr: 24'hFFFFFF, len: 16'd1, data: 32'h3C000000, dead: 1'b0, exp_err: 1'b0};
    vecs[3] = '{addr: 24'h800001, len: 16'd4, data: 32'h01807FFE, dead: 1'b0, exp_err: 1'b0};
    vecs[4] = '{addr: 24'h00ABCD, len: 16'd2, data: 32'h11220000, dead: 1'b1, exp_err: 1'b1};
    vecs[5] = '{addr: 24'h000010, len: 16'd2, data: 32'hDEAD0000, dead: 1'b0, exp_err: 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) flash_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_last", 32'(rd_last), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_byte_start", 32'(byte_start), 0);
    check("rst_byte_tx", 32'(byte_tx), 0);
    check("rst_cs_n", 32'(flash_cs_n), 1);
    check("rst_flash_sck", 32'(flash_sck), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], -1, 0);

    // Backpressure: consumer stalls 50 cycles on the third byte.
    v = '{addr: 24'h0ABCDE, len: 16'd4, data: 32'h10203040, dead: 1'b0, exp_err: 1'b0};
    run_txn(v, 2, 50);

    // Reset while ADDR1 is on the wire.
    mosi_q.delete(); exp_q.delete(); eng_dead = 1'b0;
    @(negedge clk);
    req_addr = 24'h345678; req_len = 16'd2; req_valid = 1'b1; rd_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (mosi_q.size() == 2 && byte_start) got = 1;
    end
    check("reached_addr1", 32'(got), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(flash_cs_n), 1);
    check("midrst_byte_start", 32'(byte_start), 0);
    check("midrst_rd_valid", 32'(rd_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 1);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    v = '{addr: 24'h0000F0, len: 16'd2, data: 32'h55660000, dead: 1'b0, exp_err: 1'b0};
    run_txn(v, -1, 0);

    // req_valid held high across two back-to-back transactions.
    mosi_q.delete(); exp_q.delete(); eng_dead = 1'b0;
    flash_mem[0] = 8'h77;
    exp_q.push_back({8'h77, 1'b1});
    exp_q.push_back({8'h77, 1'b1});
    @(negedge clk);
    req_addr = 24'h000100; req_len = 16'd1; req_valid = 1'b1; rd_ready = 1'b1;
    acc = 0; dn = 0; gap = 0; dn_at_acc2 = -1; busy_ready = 0; cyc = 0;
    while (dn < 2 && cyc < 1000) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      if (busy && req_ready) busy_ready++;
      consume(hs);
      if (done) dn++;
      if (dn == 1 && acc == 1 && flash_cs_n) gap++;
      if (dn == 2) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 2) dn_at_acc2 = dn;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("held_two_done", dn, 2);
    check("held_two_accepts", acc, 2);
    check("held_second_after_done", dn_at_acc2, 1);
    check("held_cs_gap", 32'(gap >= 1), 1);
    check("held_no_ready_while_busy", busy_ready, 0);
    check("held_mosi_count", mosi_q.size(), 10);
    check("held_scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
